// File: rtl/nth_root_iter.sv
// Fixed-point floor(X^(1/k)) by MSB-first bit search; powers built with a saturating multiplier, one multiply per cycle.
// Latency OUT_W*(k+1) cycles, shorter on an exact match, 1 for k=0 or X=0; the result is held until out_ready and in_ready is low while busy.
module nth_root_iter #(
    parameter int IN_W   = 10,
    parameter int FRAC_W = 10,
    parameter int DEG_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_data_1,
    input  logic [DEG_W-1:0]         in_data_2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IN_W+FRAC_W-1:0]   out_data,
    output logic                     out_exact,
    output logic                     out_err
);
    localparam int KMAX   = (1 << DEG_W) - 1;
    localparam int OUT_W  = IN_W + FRAC_W;
    localparam int P_W    = IN_W + KMAX * FRAC_W + 1;
    localparam int PROD_W = P_W + OUT_W;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_CMP, S_DONE} state_t;

    state_t             r_state;
    logic [DEG_W-1:0]   r_k;
    logic [DEG_W-1:0]   r_j;
    logic [P_W-1:0]     r_target;
    logic [P_W-1:0]     r_pow;
    logic [OUT_W-1:0]   r_res;
    logic [OUT_W-1:0]   r_base;
    logic               r_skip;

    logic [OUT_W-1:0]   w_cand;
    logic [PROD_W-1:0]  w_prod;
    logic [P_W-1:0]     w_pow_next;
    logic [P_W-1:0]     w_target;
    logic               w_take;
    logic               w_eq;
    logic               w_last_j;

    assign w_cand     = r_res | r_base;
    assign w_prod     = PROD_W'(r_pow) * PROD_W'(w_cand);
    // Any bit above P_W means the true power already exceeds every legal target.
    assign w_pow_next = (|w_prod[PROD_W-1:P_W]) ? {P_W{1'b1}} : w_prod[P_W-1:0];
    assign w_target   = {{(P_W-IN_W){1'b0}}, in_data_1} << (in_data_2 * FRAC_W);
    assign w_take     = (r_pow <= r_target);
    assign w_eq       = (r_pow == r_target);
    assign w_last_j   = (r_j == r_k - DEG_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_j       <= '0;
            r_target  <= '0;
            r_pow     <= '0;
            r_res     <= '0;
            r_base    <= '0;
            r_skip    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_exact <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_k      <= in_data_2;
                        r_j      <= '0;
                        r_target <= w_target;
                        r_res    <= '0;
                        r_base   <= {1'b1, {(OUT_W-1){1'b0}}};
                        r_skip   <= (in_data_2 == '0) || (in_data_1 == '0);
                        in_ready <= 1'b0;
                        // Degenerate requests take one CMP cycle so they report at T+1.
                        r_state  <= ((in_data_2 == '0) || (in_data_1 == '0)) ? S_CMP : S_MUL;
                    end
                end
                S_MUL: begin
                    r_pow <= (r_j == '0) ? {{(P_W-OUT_W){1'b0}}, w_cand} : w_pow_next;
                    if (w_last_j) begin
                        r_j     <= '0;
                        r_state <= S_CMP;
                    end else begin
                        r_j <= r_j + DEG_W'(1);
                    end
                end
                S_CMP: begin
                    if (r_skip) begin
                        out_data  <= '0;
                        out_exact <= (r_k != '0);
                        out_err   <= (r_k == '0);
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        if (w_take) begin
                            r_res <= w_cand;
                        end
                        r_base <= r_base >> 1;
                        if (w_eq || r_base[0]) begin
                            out_data  <= w_take ? w_cand : r_res;
                            out_exact <= w_eq;
                            out_err   <= 1'b0;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_state <= S_MUL;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nth_root_iter.sv
// Bench for nth_root_iter: fixed vectors, handshake corner sequences and random requests
// checked against a binary-search root model with cycle-accurate latency expectations.
module tb_nth_root_iter;
    localparam int IN_W   = 10;
    localparam int FRAC_W = 10;
    localparam int DEG_W  = 3;
    localparam int OUT_W  = IN_W + FRAC_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IN_W-1:0]   in_data_1 = '0;
    logic [DEG_W-1:0]  in_data_2 = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OUT_W-1:0]  out_data;
    logic              out_exact;
    logic              out_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nth_root_iter #(.IN_W(IN_W), .FRAC_W(FRAC_W), .DEG_W(DEG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data_1(in_data_1), .in_data_2(in_data_2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_exact(out_exact), .out_err(out_err)
    );

    typedef struct {
        logic [IN_W-1:0]  x;
        logic [DEG_W-1:0] k;
        logic [OUT_W-1:0] r;
        logic             ex;
        logic             er;
        int               lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [191:0] ipow(input logic [191:0] b, input int k);
        logic [191:0] p = 192'd1;
        for (int i = 0; i < k; i++) p = p * b;
        return p;
    endfunction

    // Largest R with R^k <= t, by plain binary search over the output range.
    function automatic logic [OUT_W-1:0] ref_root(input logic [191:0] t, input int k);
        logic [OUT_W:0] lo = '0;
        logic [OUT_W:0] hi = (OUT_W+1)'(1) << OUT_W;
        logic [OUT_W:0] mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) >> 1;
            if (ipow(192'(mid), k) <= t) lo = mid;
            else hi = mid;
        end
        return lo[OUT_W-1:0];
    endfunction

    function automatic int ref_lat(input int x, input int k, input logic [OUT_W-1:0] r, input bit exact);
        int tz = 0;
        if (k == 0 || x == 0) return 1;
        if (!exact) return OUT_W * (k + 1);
        while (tz < OUT_W && r[tz] == 1'b0) tz++;
        return (OUT_W - tz) * (k + 1);
    endfunction

    // Issue one request; lat counts edges from acceptance to out_valid.
    task automatic run_req(input logic [IN_W-1:0] x, input logic [DEG_W-1:0] k, input bit noise, output int lat);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_req", 64'(in_ready), 64'(1));
        in_data_1 = x;
        in_data_2 = k;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        if (noise) begin
            in_data_1 = 10'd7;
            in_data_2 = 3'd1;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_cleared", 64'(out_valid), 64'(0));
        chk("in_ready_restored", 64'(in_ready), 64'(1));
    endtask

    initial begin
        vec_t vecs[10];
        int lat;
        int m;
        int gap;
        logic [IN_W-1:0]  rx;
        logic [DEG_W-1:0] rk;
        logic [191:0]     t;
        logic [OUT_W-1:0] rr;
        bit               rex;

        vecs[0] = '{x: 10'd64,   k: 3'd3, r: 20'd4096,    ex: 1'b1, er: 1'b0, lat: 32};
        vecs[1] = '{x: 10'd2,    k: 3'd2, r: 20'd1448,    ex: 1'b0, er: 1'b0, lat: 60};
        vecs[2] = '{x: 10'd1023, k: 3'd7, r: 20'd2756,    ex: 1'b0, er: 1'b0, lat: 160};
        vecs[3] = '{x: 10'd1000, k: 3'd7, r: 20'd2747,    ex: 1'b0, er: 1'b0, lat: 160};
        vecs[4] = '{x: 10'd500,  k: 3'd0, r: 20'd0,       ex: 1'b0, er: 1'b1, lat: 1};
        vecs[5] = '{x: 10'd0,    k: 3'd5, r: 20'd0,       ex: 1'b1, er: 1'b0, lat: 1};
        vecs[6] = '{x: 10'd1,    k: 3'd4, r: 20'd1024,    ex: 1'b1, er: 1'b0, lat: 50};
        vecs[7] = '{x: 10'd1023, k: 3'd2, r: 20'd32751,   ex: 1'b0, er: 1'b0, lat: 60};
        vecs[8] = '{x: 10'd16,   k: 3'd4, r: 20'd2048,    ex: 1'b1, er: 1'b0, lat: 45};
        vecs[9] = '{x: 10'd1023, k: 3'd1, r: 20'd1047552, ex: 1'b1, er: 1'b0, lat: 20};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_out_exact", 64'(out_exact), 64'(0));
        chk("rst_out_err",   64'(out_err),   64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].x, vecs[i].k, 1'b0, lat);
            chk($sformatf("vec%0d_data", i),  64'(out_data),  64'(vecs[i].r));
            chk($sformatf("vec%0d_exact", i), 64'(out_exact), 64'(vecs[i].ex));
            chk($sformatf("vec%0d_err", i),   64'(out_err),   64'(vecs[i].er));
            chk($sformatf("vec%0d_lat", i),   64'(lat),       64'(vecs[i].lat));
            take_result();
        end

        // Consumer stalls: result and flags must stay put, no new request accepted.
        run_req(10'd2, 3'd2, 1'b0, lat);
        chk("hold_lat", 64'(lat), 64'(60));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("hold_valid",    64'(out_valid), 64'(1));
            chk("hold_data",     64'(out_data),  64'(1448));
            chk("hold_exact",    64'(out_exact), 64'(0));
            chk("hold_in_ready", 64'(in_ready),  64'(0));
        end
        take_result();

        // Requests presented while busy must not disturb the running search.
        run_req(10'd1000, 3'd7, 1'b1, lat);
        chk("busy_data", 64'(out_data), 64'(2747));
        chk("busy_lat",  64'(lat),      64'(160));
        take_result();

        // Leave an exact nonzero result on the outputs, then reset mid-MUL.
        run_req(10'd1023, 3'd1, 1'b0, lat);
        take_result();
        @(negedge clk);
        in_data_1 = 10'd500;
        in_data_2 = 3'd7;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  64'(in_ready),  64'(1));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_out_data",  64'(out_data),  64'(0));
        chk("midrst_out_exact", 64'(out_exact), 64'(0));
        chk("midrst_out_err",   64'(out_err),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_req(10'd64, 3'd3, 1'b0, lat);
        chk("postrst_data",  64'(out_data),  64'(4096));
        chk("postrst_exact", 64'(out_exact), 64'(1));
        chk("postrst_lat",   64'(lat),       64'(32));
        take_result();

        // Back-to-back with both sides always willing: one IDLE cycle between results.
        @(negedge clk);
        out_ready = 1'b1;
        in_data_1 = 10'd1;
        in_data_2 = 3'd4;
        in_valid  = 1'b1;
        m = 0;
        while (!out_valid && m < 200) begin
            @(posedge clk);
            #1;
            m++;
        end
        chk("b2b_first_data", 64'(out_data), 64'(1024));
        m = 0;
        gap = 0;
        do begin
            @(posedge clk);
            #1;
            m++;
            if (in_ready) gap++;
        end while (!out_valid && m < 200);
        chk("b2b_second_data", 64'(out_data), 64'(1024));
        chk("b2b_period",      64'(m),        64'(52));
        chk("b2b_idle_gap",    64'(gap),      64'(1));
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;

        for (int i = 0; i < 40; i++) begin
            rx = IN_W'($urandom_range(0, 1023));
            rk = DEG_W'($urandom_range(0, 7));
            run_req(rx, rk, 1'b0, lat);
            t   = 192'(rx) << (int'(rk) * FRAC_W);
            rr  = (rk == 0) ? '0 : ref_root(t, int'(rk));
            rex = (rk != 0) && (ipow(192'(rr), int'(rk)) == t);
            chk($sformatf("rnd%0d_data x=%0d k=%0d", i, rx, rk), 64'(out_data), 64'(rr));
            chk($sformatf("rnd%0d_exact", i), 64'(out_exact), 64'(rex));
            chk($sformatf("rnd%0d_err", i),   64'(out_err),   64'(rk == 0));
            chk($sformatf("rnd%0d_lat", i),   64'(lat),       64'(ref_lat(int'(rx), int'(rk), rr, rex)));
            if (rk != 0) begin
                chk($sformatf("rnd%0d_bracket", i),
                    64'((ipow(192'(out_data), int'(rk)) <= t) && (t < ipow(192'(out_data) + 192'd1, int'(rk)))),
                    64'(1));
            end
            take_result();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
